// File: rtl/chunk_serial_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands processed CHUNK bits per clock,
// LSB chunk first, through a single shared CHUNK-bit carry chain.
//
//   state | meaning
//   IDLE  | waiting for start; result registers hold the last result
//   RUN   | one chunk per cycle, counter selects the chunk
//   DONE  | one-cycle done pulse; start here begins the next operation
module chunk_serial_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic             Ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sout,
  output logic             Co,
  output logic             Ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, part_q, part_d, sout_q;
  logic             carry_q, co_q, ovf_q;
  logic [CW-1:0]    cnt_q;
  logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
  logic             carry_out, carry_msb, last, accept;

  // Chunk mux and partial-result merge use constant slices only.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    part_d  = part_q;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CW'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
        part_d[i*CHUNK +: CHUNK] = sum_chunk;
      end
    end
  end

  assign {carry_out, sum_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
  // Carry into the top bit of the chunk, recovered from the sum bit.
  assign carry_msb = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ sum_chunk[CHUNK-1];
  assign last      = (cnt_q == CW'(N - 1));
  assign accept    = start && (state_q != RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    Sout = sout_q;
    Co   = co_q;
    Ovf  = ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sout_q  <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= Ain;
      b_q     <= sub ? ~Bin : Bin;
      carry_q <= sub ? 1'b1 : Ci;
      cnt_q   <= '0;
      part_q  <= '0;
    end else if (state_q == RUN) begin
      part_q  <= part_d;
      carry_q <= carry_out;
      cnt_q   <= cnt_q + CW'(1);
      if (last) begin
        sout_q <= part_d;
        co_q   <= carry_out;
        ovf_q  <= carry_msb ^ carry_out;
      end
    end
  end

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Bench for chunk_serial_adder: directed scenarios on a CHUNK=8 instance plus a
// random regression across CHUNK=8/4/32 against an arithmetic reference model.
module tb_chunk_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n, start, sub, Ci;
  logic [31:0] Ain, Bin;

  logic        busy8, done8, co8, ovf8;
  logic [31:0] s8;
  logic        busy4, done4, co4, ovf4;
  logic [31:0] s4;
  logic        busy32, done32, co32, ovf32;
  logic [31:0] s32;

  int n_cmp = 0;
  int n_err = 0;

  chunk_serial_adder #(.WIDTH(32), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .Ain(Ain), .Bin(Bin), .Ci(Ci),
    .busy(busy8), .done(done8), .Sout(s8), .Co(co8), .Ovf(ovf8));

  chunk_serial_adder #(.WIDTH(32), .CHUNK(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .Ain(Ain), .Bin(Bin), .Ci(Ci),
    .busy(busy4), .done(done4), .Sout(s4), .Co(co4), .Ovf(ovf4));

  chunk_serial_adder #(.WIDTH(32), .CHUNK(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .Ain(Ain), .Bin(Bin), .Ci(Ci),
    .busy(busy32), .done(done32), .Sout(s32), .Co(co32), .Ovf(ovf32));

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain wide arithmetic, returns {Ovf, Co, Sout}.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic ci, input logic s);
    logic [31:0] bp;
    logic [32:0] full;
    logic        ov;
    bp   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bp} + {32'd0, (s ? 1'b1 : ci)};
    ov   = (a[31] == bp[31]) && (full[31] != a[31]);
    return {ov, full[32], full[31:0]};
  endfunction

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic s);
    Ain = a; Bin = b; Ci = ci; sub = s; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Advance until done8 is seen; lat = ticks after the start tick, -1 on timeout.
  task automatic wait_done8(output int lat, output int busy_cnt);
    lat = -1;
    busy_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      if (busy8) busy_cnt++;
      tick();
      if (done8) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; Ci = 1'b0; Ain = '0; Bin = '0;
    #3;
    n_cmp++;
    if ({busy8, done8, co8, ovf8, s8} !== 36'd0) begin
      n_err++;
      $display("FAIL reset_dut8: got busy=%b done=%b co=%b ovf=%b sout=%h, expected all 0", busy8, done8, co8, ovf8, s8);
    end
    n_cmp++;
    if ({busy4, done4, co4, ovf4, s4, busy32, done32, co32, ovf32, s32} !== 72'd0) begin
      n_err++;
      $display("FAIL reset_dut4_32: got s4=%h s32=%h busy4=%b busy32=%b, expected all 0", s4, s32, busy4, busy32);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add;
    int lat, bc;
    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    wait_done8(lat, bc);
    n_cmp++;
    if (lat !== 4) begin n_err++; $display("FAIL add_latency: got %0d expected 4", lat); end
    n_cmp++;
    if (bc !== 4) begin n_err++; $display("FAIL add_busy_cycles: got %0d expected 4", bc); end
    n_cmp++;
    if ({ovf8, co8, s8} !== {1'b0, 1'b0, 32'h0000_0100}) begin
      n_err++; $display("FAIL add_carry_chunk: got sout=%h co=%b ovf=%b expected 00000100 0 0", s8, co8, ovf8);
    end
    tick();
    do_op(32'h0, 32'h0, 1'b1, 1'b0);
    wait_done8(lat, bc);
    n_cmp++;
    if ({ovf8, co8, s8} !== {1'b0, 1'b0, 32'h0000_0001}) begin
      n_err++; $display("FAIL add_ci: got sout=%h co=%b ovf=%b expected 00000001 0 0", s8, co8, ovf8);
    end
    tick();
  endtask

  task automatic test_overflow;
    int lat, bc;
    do_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    wait_done8(lat, bc);
    n_cmp++;
    if ({ovf8, co8, s8} !== {1'b0, 1'b1, 32'h0}) begin
      n_err++; $display("FAIL full_wrap: got sout=%h co=%b ovf=%b expected 00000000 1 0", s8, co8, ovf8);
    end
    tick();
    do_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    wait_done8(lat, bc);
    n_cmp++;
    if ({ovf8, co8, s8} !== {1'b1, 1'b0, 32'h8000_0000}) begin
      n_err++; $display("FAIL signed_ovf: got sout=%h co=%b ovf=%b expected 80000000 0 1", s8, co8, ovf8);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    do_op(32'd5, 32'd7, 1'b1, 1'b1);
    wait_done8(lat, bc);
    n_cmp++;
    if ({ovf8, co8, s8} !== {1'b0, 1'b0, 32'hFFFF_FFFE}) begin
      n_err++; $display("FAIL sub_borrow: got sout=%h co=%b ovf=%b expected fffffffe 0 0", s8, co8, ovf8);
    end
    do_op(32'd7, 32'd5, 1'b0, 1'b1);
    n_cmp++;
    if ({busy8, s8} !== {1'b1, 32'hFFFF_FFFE}) begin
      n_err++; $display("FAIL b2b_accept_hold: got busy=%b sout=%h expected 1 fffffffe", busy8, s8);
    end
    wait_done8(lat, bc);
    n_cmp++;
    if (lat !== 4) begin n_err++; $display("FAIL b2b_latency: got %0d expected 4", lat); end
    n_cmp++;
    if ({ovf8, co8, s8} !== {1'b0, 1'b1, 32'd2}) begin
      n_err++; $display("FAIL sub_no_borrow: got sout=%h co=%b ovf=%b expected 00000002 1 0", s8, co8, ovf8);
    end
    tick();
  endtask

  task automatic test_handshake;
    int dones = 0;
    int early = 0;
    do_op(32'd1, 32'd2, 1'b0, 1'b0);
    tick();
    Ain = 32'd100; Bin = 32'd200; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (done8) dones++;
      else if (dones == 0 && s8 !== 32'd2) early++;
      tick();
    end
    n_cmp++;
    if (dones !== 1) begin n_err++; $display("FAIL ignore_start_dones: got %0d expected 1", dones); end
    n_cmp++;
    if (early !== 0) begin n_err++; $display("FAIL sout_hold: got %0d early changes expected 0", early); end
    n_cmp++;
    if (s8 !== 32'd3) begin n_err++; $display("FAIL ignore_start_result: got %h expected 00000003", s8); end
  endtask

  task automatic test_reset_mid;
    int dones = 0;
    int lat, bc;
    do_op(32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0);
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy8, done8, co8, ovf8, s8} !== 36'd0) begin
      n_err++; $display("FAIL async_reset: got busy=%b done=%b co=%b ovf=%b sout=%h expected all 0", busy8, done8, co8, ovf8, s8);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (done8) dones++;
      tick();
    end
    n_cmp++;
    if (dones !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d done pulses expected 0", dones); end
    do_op(32'd10, 32'd20, 1'b0, 1'b0);
    wait_done8(lat, bc);
    n_cmp++;
    if (s8 !== 32'd30 || lat !== 4) begin
      n_err++; $display("FAIL after_reset_op: got sout=%h lat=%0d expected 0000001e 4", s8, lat);
    end
    tick();
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    logic        ci, s;
    logic [33:0] exp_r;
    int          l8, l4, l32;
    logic [33:0] r8, r4, r32;
    for (int k = 0; k < 8; k++) tick();
    for (int n = 0; n < 1000; n++) begin
      a  = $urandom();
      b  = $urandom();
      ci = 1'($urandom_range(0, 1));
      s  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: a = 32'hFFFF_FFFF;
        1: a = 32'h7FFF_FFFF;
        2: b = 32'h8000_0000;
        3: b = 32'h0;
        default: ;
      endcase
      exp_r = model(a, b, ci, s);
      do_op(a, b, ci, s);
      l8 = -1; l4 = -1; l32 = -1;
      r8 = '0; r4 = '0; r32 = '0;
      for (int c = 1; c <= 10; c++) begin
        tick();
        if (done8  && l8  < 0) begin l8  = c; r8  = {ovf8,  co8,  s8};  end
        if (done4  && l4  < 0) begin l4  = c; r4  = {ovf4,  co4,  s4};  end
        if (done32 && l32 < 0) begin l32 = c; r32 = {ovf32, co32, s32}; end
      end
      n_cmp++;
      if (l8 !== 4 || r8 !== exp_r) begin
        n_err++; $display("FAIL rand_c8 #%0d: got lat=%0d res=%h expected lat=4 res=%h", n, l8, r8, exp_r);
      end
      n_cmp++;
      if (l4 !== 8 || r4 !== exp_r) begin
        n_err++; $display("FAIL rand_c4 #%0d: got lat=%0d res=%h expected lat=8 res=%h", n, l4, r4, exp_r);
      end
      n_cmp++;
      if (l32 !== 1 || r32 !== exp_r) begin
        n_err++; $display("FAIL rand_c32 #%0d: got lat=%0d res=%h expected lat=1 res=%h", n, l32, r32, exp_r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_overflow();
    test_back_to_back();
    test_handshake();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
